spdif_aes3_tx_cs: RTL and testbench

SPDIF_AES3_TX_CS -- requirements
Module: spdif_aes3_tx_cs

---
 rtl/spdif_aes3_tx_cs.sv | 110 +++++++++++
 tb/tb_spdif_aes3_tx_cs.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spdif_aes3_tx_cs.sv
// spdif_aes3_tx_cs: S/PDIF / AES3 transmitter with stereo sample FIFO and channel-status block.
//   clk            time-slot clock, one clk per half-bit (128 clk per frame)
//   rst_n          asynchronous active-low reset, released synchronously
//   en_i           slot advance enable; low freezes counters, handshakes and tx_o
//   sample_i       {right, left} samples, SAMPLE_WIDTH bits each, left in the LSBs
//   sample_valid_i / sample_ready_o   sample handshake, ready = FIFO not full
//   cs_i           192-bit channel-status block, latched once per block
//   user_i         user bits {R, L}, captured at each frame load
//   tx_o           biphase-mark line output
//   block_start_o  pulse at the first preamble slot of frame 0
//   underrun_o     pulse when a frame loads from an empty FIFO
// Optional: define SPDIF_CS_CRC_EN to replace channel-status bits 184..191 with the CRCC.
module spdif_aes3_tx_cs #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic [2*SAMPLE_WIDTH-1:0] sample_i,
  input  logic                      sample_valid_i,
  output logic                      sample_ready_o,
  input  logic [191:0]              cs_i,
  input  logic [1:0]                user_i,
  output logic                      tx_o,
  output logic                      block_start_o,
  output logic                      underrun_o
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PAD = 24 - SAMPLE_WIDTH;
  logic [2*SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [2*SAMPLE_WIDTH-1:0] head;
  logic [AW:0] wp, rp;
  logic full, empty, push, pop, load;
  logic [5:0] slot;
  logic sub;
  logic [7:0] frame;
  logic [23:0] aud_l, aud_r, aud;
  logic v;
  logic [1:0] u;
  logic [191:0] shadow;
  logic c_bit, par, nxt;
  logic [31:0] sf;
  logic [7:0] pat, tog;
  // One extra pointer bit distinguishes full from empty.
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign sample_ready_o = !full;
  assign push = en_i && sample_valid_i && !full;
  assign load = en_i && slot == 6'd63 && sub;
  assign pop = load && !empty;
  assign head = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= sample_i;
`ifdef SPDIF_CS_CRC_EN
  logic [7:0] crc;
  // Serial CRCC over the C bits of frames 0..183 as they go out; restarts each block.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) crc <= 8'hFF;
    else if (load) crc <= frame == 8'd191 ? 8'hFF : (frame < 8'd184 ? ({crc[6:0], 1'b0} ^ ({8{crc[7] ^ shadow[frame]}} & 8'h1D)) : crc);
`endif
  always_comb begin
    aud = sub ? aud_r : aud_l;
`ifdef SPDIF_CS_CRC_EN
    c_bit = frame >= 8'd184 ? crc[frame[2:0]] : shadow[frame];
`else
    c_bit = shadow[frame];
`endif
    par = ^{aud, v, u[sub], c_bit};
    sf = {par, c_bit, u[sub], v, aud, 4'b0};
    // Preamble patterns (bit n = slot n, relative to a low line) turned into per-slot toggles.
    pat = sub ? 8'h27 : (frame == 8'd0 ? 8'h17 : 8'h47);
    tog = pat ^ {pat[6:0], 1'b0};
    nxt = slot < 6'd8 ? tx_o ^ tog[slot[2:0]] : (slot[0] ? tx_o ^ sf[slot[5:1]] : !tx_o);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      slot <= '0;
      sub <= 1'b0;
      frame <= '0;
      aud_l <= '0;
      aud_r <= '0;
      v <= 1'b1;
      u <= '0;
      shadow <= '0;
      tx_o <= 1'b0;
      block_start_o <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      block_start_o <= en_i && slot == 6'd0 && !sub && frame == 8'd0;
      underrun_o <= load && empty;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (en_i) begin
        tx_o <= nxt;
        slot <= slot + 1'b1;
        if (slot == 6'd63) sub <= !sub;
        if (load) begin
          frame <= frame == 8'd191 ? 8'd0 : frame + 8'd1;
          aud_l <= empty ? '0 : 24'(head[SAMPLE_WIDTH-1:0]) << PAD;
          aud_r <= empty ? '0 : 24'(head[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH]) << PAD;
          v <= empty;
          u <= user_i;
          if (frame == 8'd191) shadow <= cs_i;
        end
      end
    end
endmodule

// File: tb/tb_spdif_aes3_tx_cs.sv
// tb_spdif_aes3_tx_cs: decodes tx_o slot by slot and scores every subframe against queued samples.
module tb_spdif_aes3_tx_cs;
  localparam int SW = 16;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst_n, en_i, sample_valid_i, sample_ready_o, tx_o, block_start_o, underrun_o;
  logic [2*SW-1:0] sample_i;
  logic [191:0] cs_i;
  logic [1:0] user_i;
  int checks = 0, errors = 0;
  int mts = 0, mfr = 0, nblk = 0;
  logic msub = 1'b0;
  logic [2*SW-1:0] mq [$];
  logic [23:0] e_l, e_r;
  logic e_v;
  logic [1:0] e_u;
  logic [191:0] msh;
  logic lv [64];
  logic pl, last_tx, rdy_q;
`ifdef SPDIF_CS_CRC_EN
  logic [7:0] mcrc;
  function automatic logic [7:0] crc_ref(input logic [191:0] sh);
    logic [7:0] c = 8'hFF;
    for (int i = 0; i < 184; i++) c = {c[6:0], 1'b0} ^ ((c[7] ^ sh[i]) ? 8'h1D : 8'h00);
    return c;
  endfunction
`endif
  spdif_aes3_tx_cs #(.SAMPLE_WIDTH(SW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .sample_i(sample_i),
    .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
    .cs_i(cs_i), .user_i(user_i), .tx_o(tx_o),
    .block_start_o(block_start_o), .underrun_o(underrun_o));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask
  always @(posedge clk) begin : mon
    logic e, vld, hs, ld, ebs, bnd, cexp;
    logic [2*SW-1:0] smp, s;
    logic [1:0] usr;
    logic [191:0] csv;
    logic [7:0] pat, epat;
    logic [31:0] w;
    e = en_i;
    vld = sample_valid_i;
    smp = sample_i;
    usr = user_i;
    csv = cs_i;
    #1;
    if (!rst_n) begin
      mts = 0; msub = 1'b0; mfr = 0; mq.delete();
      e_l = '0; e_r = '0; e_v = 1'b1; e_u = '0; msh = '0; pl = 1'b0;
`ifdef SPDIF_CS_CRC_EN
      mcrc = crc_ref('0);
`endif
      chk("rst_tx", tx_o, 0);
      chk("rst_block_start", block_start_o, 0);
      chk("rst_underrun", underrun_o, 0);
      chk("rst_ready", sample_ready_o, 1);
    end else if (!e) begin
      chk("hold_tx", tx_o, last_tx);
      chk("hold_block_start", block_start_o, 0);
      chk("hold_underrun", underrun_o, 0);
    end else begin
      chk("ready", rdy_q, mq.size() < DEPTH);
      hs = vld && mq.size() < DEPTH;
      ld = mts == 63 && msub;
      ebs = mts == 0 && !msub && mfr == 0;
      if (ebs) nblk++;
      lv[mts] = tx_o;
      chk("block_start", block_start_o, ebs);
      chk("underrun", underrun_o, ld && mq.size() == 0);
      if (mts == 63) begin
        for (int i = 0; i < 8; i++) pat[i] = lv[i] ^ pl;
        epat = msub ? 8'b00100111 : (mfr == 0 ? 8'b00010111 : 8'b01000111);
        chk("preamble", pat, epat);
        bnd = 1'b1;
        w = '0;
        for (int b = 4; b < 32; b++) begin
          if (lv[2*b] == lv[2*b-1]) bnd = 1'b0;
          w[b] = lv[2*b] ^ lv[2*b+1];
        end
`ifdef SPDIF_CS_CRC_EN
        cexp = mfr >= 184 ? mcrc[mfr-184] : msh[mfr];
`else
        cexp = msh[mfr];
`endif
        chk("bmc_edges", bnd, 1);
        chk(msub ? "audio_r" : "audio_l", w[27:4], msub ? e_r : e_l);
        chk("v_bit", w[28], e_v);
        chk("u_bit", w[29], e_u[msub]);
        chk("c_bit", w[30], cexp);
        chk("parity", ^w[31:4], 0);
        pl = lv[63];
      end
      if (ld) begin
        if (mfr == 191) begin
          msh = csv;
`ifdef SPDIF_CS_CRC_EN
          mcrc = crc_ref(csv);
`endif
        end
        if (mq.size() > 0) begin
          s = mq.pop_front();
          e_l = {s[SW-1:0], {(24-SW){1'b0}}};
          e_r = {s[2*SW-1:SW], {(24-SW){1'b0}}};
          e_v = 1'b0;
        end else begin
          e_l = '0; e_r = '0; e_v = 1'b1;
        end
        e_u = usr;
      end
      if (hs) mq.push_back(smp);
      if (mts == 63) begin
        if (msub) mfr = mfr == 191 ? 0 : mfr + 1;
        msub = !msub;
        mts = 0;
      end else mts++;
    end
    last_tx = tx_o;
    rdy_q = sample_ready_o;
  end
  task automatic push(input logic [2*SW-1:0] x);
    int n = 0;
    while (!sample_ready_o && n < 2000) begin @(negedge clk); n++; end
    chk("push_wait", sample_ready_o, 1);
    sample_i = x;
    sample_valid_i = 1'b1;
    @(negedge clk);
    sample_valid_i = 1'b0;
  endtask
  task automatic wait_frame(input int blk, input int fr);
    int n = 0;
    while (!(nblk > blk || (nblk == blk && mfr >= fr)) && n < 60000) begin @(negedge clk); n++; end
    chk("frame_wait", n < 60000, 1);
  endtask
  task automatic wait_slot(input int ts, input logic sb);
    int n = 0;
    while (!(mts == ts && msub == sb) && n < 300) begin @(negedge clk); n++; end
    chk("slot_wait", n < 300, 1);
  endtask
  initial begin
    rst_n = 1'b0; en_i = 1'b1; sample_valid_i = 1'b0; sample_i = '0; cs_i = '0; user_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_frame(1, 2);
    user_i = 2'b01;
    push({16'h0000, 16'h8001});
    wait_frame(1, 5);
    cs_i = '0;
    cs_i[0] = 1'b1;
    cs_i[1] = 1'b1;
    cs_i[190] = 1'b1;
    user_i = 2'b10;
    push(32'h1234_5678);
    push(32'hFFFF_0001);
    chk("full_ready", sample_ready_o, 0);
    push(32'hA5A5_5A5A);
    wait_frame(1, 12);
    push(32'h0F0F_F0F0);
    wait_slot(63, 1'b1);
    sample_i = 32'h8000_7FFF;
    sample_valid_i = 1'b1;
    @(negedge clk);
    sample_valid_i = 1'b0;
    chk("push_pop_ready", sample_ready_o, 1);
    push(32'h0001_8000);
    chk("refill_full", sample_ready_o, 0);
    wait_frame(1, 20);
    wait_slot(30, 1'b0);
    en_i = 1'b0;
    repeat (10) @(negedge clk);
    en_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      user_i = 2'($urandom);
      push($urandom);
    end
    wait_frame(2, 10);
    cs_i = '0;
    cs_i[2] = 1'b1;
    cs_i[191] = 1'b1;
    wait_frame(3, 3);
    push(32'h1111_2222);
    push(32'h3333_4444);
    chk("pre_reset_full", sample_ready_o, 0);
    wait_slot(20, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("async_reset_ready", sample_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
